gpio_in_cond: RTL and testbench
===============================

// Module: gpio_in_cond
// PURPOSE
//  Input conditioner for the SoC GPIO input port. Synchronises raw pad inputs
//  into clk, debounces each bit, and drives the clean level into soc_6502.gpio_i.
//  Latches per-bit edge events into sticky flags that firmware clears via a
//  write strobe; raises a level irq while any flag is set.
// PARAMETERS
//  WIDTH      8     number of GPIO input bits
//  DB_CYCLES  16    consecutive stable cycles required to accept a new level (>=1)
//  RESET_VAL  0     per-bit reset value of synchroniser and clean level [WIDTH-1:0]
// PORTS
//  clk       in   1      system clock
//  reset_n   in   1      asynchronous, active-low reset
//  pin_i     in   WIDTH  raw asynchronous pad inputs
//  rise_en   in   WIDTH  per-bit enable: 0->1 of clean level sets flag
//  fall_en   in   WIDTH  per-bit enable: 1->0 of clean level sets flag
//  clr_we    in   1      single-cycle flag clear strobe
//  clr_mask  in   WIDTH  bits to clear when clr_we=1
//  gpio_i    out  WIDTH  debounced level; connects to soc_6502.gpio_i
//  edge_flag out  WIDTH  sticky edge flags
//  irq       out  1      |edge_flag
// BEHAVIOUR
//  - Reset (reset_n=0, async, any time incl. mid-debounce): sync stages and
//    gpio_i <= RESET_VAL; all debounce counters <= 0; edge_flag <= 0; irq = 0.
//  - Sync: two-flop chain per bit, s1 <= pin_i, s2 <= s1. No logic on s1.
//  - Debounce, per bit, counter width $clog2(DB_CYCLES+1):
//    s2 == gpio_i[i]: cnt <= 0.
//    s2 != gpio_i[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
//    s2 != gpio_i[i] and cnt == DB_CYCLES-1: gpio_i[i] <= s2, cnt <= 0.
//    Any return to agreement before acceptance resets cnt (glitch rejected).
//  - Latency: pin change stable before edge k -> gpio_i updates at edge
//    k+DB_CYCLES+1 (DB_CYCLES+2 edges counting edge k). Pulse shorter than
//    DB_CYCLES cycles at s2 never reaches gpio_i.
//  - Edge detect on the gpio_i register update itself (same edge, no extra
//    delay): set_i = (rise_en[i] & 0->1) | (fall_en[i] & 1->0).
//  - Flags: edge_flag[i] <= set_i | (edge_flag[i] & ~(clr_we & clr_mask[i])).
//    Simultaneous set and clear on the same bit: set wins (flag stays 1).
//    Clearing an already-clear bit or clr_mask=0 has no effect.
//  - irq: combinational OR of edge_flag registers; glitch-free, drops the
//    cycle after the last flag is cleared.
//  - Enables sampled on the edge where gpio_i changes; changing them never
//    sets or clears flags on its own.
//  - Bits fully independent; no cross-bit state.
//  - Post-reset: if pin_i != RESET_VAL, gpio_i follows after normal latency
//    and that transition sets flags per enables (not suppressed).
// TESTING (DB_CYCLES=4, WIDTH=8, RESET_VAL=0)
//  1 reset_n=0, pin_i=8'hFF, rise_en=8'hFF -> gpio_i=00, edge_flag=00, irq=0;
//    release before edge k -> gpio_i=FF and edge_flag=FF at edge k+5, irq=1.
//  2 pin_i[0] high 3 cycles then low -> gpio_i[0] stays 0, edge_flag[0]=0.
//  3 pin_i[3] 0->1 held, rise_en[3]=1 -> gpio_i[3] and edge_flag[3] rise on
//    exactly the 6th edge; irq=1 same cycle; no change one edge earlier.
//  4 edge_flag=08, clr_we=1 clr_mask=08 -> edge_flag=00, irq=0 next edge;
//    repeat with a new bit-3 rise accepted on the clear edge -> edge_flag[3]=1.
//  5 fall_en[5]=1, rise_en[5]=0: bit5 0->1 -> no flag; 1->0 -> edge_flag[5]=1.
//  6 pin_i[2] 0->1, assert reset_n after 2 stable cycles, release -> counter
//    restarts: gpio_i[2] rises 6 edges after release, not earlier.

Source files
------------

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: two-flop synchroniser, per-bit debounce, sticky
// edge flags with firmware clear, and a level irq while any flag is set.
module gpio_in_cond #(
    parameter int               WIDTH     = 8,
    parameter int               DB_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic             clr_we,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] edge_flag,
    output logic             irq
);

    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_flag;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_level_next;
    logic [WIDTH-1:0] w_flag_next;
    logic [WIDTH-1:0] w_set;
    logic [CW-1:0]    w_cnt_next [WIDTH];

    // Counter advances only while the synchronised pin disagrees with the
    // accepted level; any agreement discards the partial count.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_level_next = r_level;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (r_s2[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_level_next[i] = r_s2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edges are taken from the level update itself, so a flag appears on the
    // same edge gpio_i changes; a new event beats a simultaneous clear.
    assign w_set       = (rise_en & w_level_next & ~r_level)
                       | (fall_en & ~w_level_next & r_level);
    assign w_flag_next = w_set | (r_flag & ~({WIDTH{clr_we}} & clr_mask));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= RESET_VAL;
            r_s2    <= RESET_VAL;
            r_level <= RESET_VAL;
            r_flag  <= '0;
            // NOTE: the counter array is plain flops, so it is reset like any register.
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= pin_i;
            r_s2    <= r_s1;
            r_level <= w_level_next;
            r_flag  <= w_flag_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign gpio_i    = r_level;
    assign edge_flag = r_flag;
    assign irq       = |r_flag;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed-vector bench for gpio_in_cond with DB_CYCLES=4, WIDTH=8, RESET_VAL=0.
module tb_gpio_in_cond;

    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] pin_i;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic         clr_we;
    logic [W-1:0] clr_mask;
    logic [W-1:0] gpio_i;
    logic [W-1:0] edge_flag;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_in_cond #(
        .WIDTH     (W),
        .DB_CYCLES (DB),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_i     (pin_i),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .clr_we    (clr_we),
        .clr_mask  (clr_mask),
        .gpio_i    (gpio_i),
        .edge_flag (edge_flag),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_flags(input logic [W-1:0] mask);
        clr_we   = 1'b1;
        clr_mask = mask;
        tick(1);
        clr_we   = 1'b0;
        clr_mask = '0;
    endtask

    initial begin
        // 1: reset with all pins high, then release; all bits rise at edge k+5
        reset_n  = 1'b0;
        pin_i    = 8'hFF;
        rise_en  = 8'hFF;
        fall_en  = 8'h00;
        clr_we   = 1'b0;
        clr_mask = 8'h00;
        tick(2);
        check("rst_gpio", 32'(gpio_i), 32'h00);
        check("rst_flag", 32'(edge_flag), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick(5);
        check("t1_gpio_early", 32'(gpio_i), 32'h00);
        tick(1);
        check("t1_gpio", 32'(gpio_i), 32'hFF);
        check("t1_flag", 32'(edge_flag), 32'hFF);
        check("t1_irq", 32'(irq), 32'h1);
        clear_flags(8'hFF);
        check("t1_clr_flag", 32'(edge_flag), 32'h00);
        check("t1_clr_irq", 32'(irq), 32'h0);

        // Return all pins low with no enables: level follows, no flags
        rise_en = 8'h00;
        pin_i   = 8'h00;
        tick(6);
        check("prep_gpio", 32'(gpio_i), 32'h00);
        check("prep_flag", 32'(edge_flag), 32'h00);

        // 2: three-cycle pulse on bit 0 is rejected
        rise_en = 8'hFF;
        pin_i   = 8'h01;
        tick(3);
        pin_i   = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t2_glitch_gpio0", 32'(gpio_i[0]), 32'h0);
        end
        check("t2_flag", 32'(edge_flag), 32'h00);

        // 3: bit 3 rise appears exactly on the 6th edge
        rise_en = 8'h08;
        pin_i   = 8'h08;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t3_gpio_early", 32'(gpio_i), 32'h00);
        end
        tick(1);
        check("t3_gpio", 32'(gpio_i), 32'h08);
        check("t3_flag", 32'(edge_flag), 32'h08);
        check("t3_irq", 32'(irq), 32'h1);

        // 4: clear, then set-wins when a new rise lands on the clear edge
        clear_flags(8'h08);
        check("t4_clr_flag", 32'(edge_flag), 32'h00);
        check("t4_clr_irq", 32'(irq), 32'h0);
        pin_i = 8'h00;
        tick(6);
        check("t4_fall_gpio", 32'(gpio_i), 32'h00);
        check("t4_fall_noflag", 32'(edge_flag), 32'h00);
        pin_i = 8'h08;
        tick(5);
        check("t4_gpio_early", 32'(gpio_i), 32'h00);
        clear_flags(8'h08);
        check("t4_setwin_gpio", 32'(gpio_i), 32'h08);
        check("t4_setwin_flag", 32'(edge_flag), 32'h08);
        check("t4_setwin_irq", 32'(irq), 32'h1);
        clear_flags(8'h08);
        check("t4_clr2_flag", 32'(edge_flag), 32'h00);

        // 5: fall-only enable on bit 5; enable changes and empty clears are inert
        rise_en = 8'h00;
        fall_en = 8'h20;
        pin_i   = 8'h28;
        tick(6);
        check("t5_rise_gpio", 32'(gpio_i), 32'h28);
        check("t5_rise_noflag", 32'(edge_flag), 32'h00);
        pin_i = 8'h08;
        tick(6);
        check("t5_fall_gpio", 32'(gpio_i), 32'h08);
        check("t5_fall_flag", 32'(edge_flag), 32'h20);
        check("t5_fall_irq", 32'(irq), 32'h1);
        rise_en = 8'hFF;
        fall_en = 8'h00;
        tick(2);
        check("t5_en_change", 32'(edge_flag), 32'h20);
        clear_flags(8'hDF);
        check("t5_clr_other", 32'(edge_flag), 32'h20);
        clear_flags(8'h20);
        check("t5_clr_flag", 32'(edge_flag), 32'h00);
        check("t5_clr_irq", 32'(irq), 32'h0);

        // 6: reset mid-debounce restarts the count from release
        rise_en = 8'h04;
        fall_en = 8'h00;
        pin_i   = 8'h0C;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("t6_async_gpio", 32'(gpio_i), 32'h00);
        check("t6_async_irq", 32'(irq), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        check("t6_gpio_early", 32'(gpio_i), 32'h00);
        tick(1);
        check("t6_gpio", 32'(gpio_i), 32'h0C);
        check("t6_flag", 32'(edge_flag), 32'h04);
        check("t6_irq", 32'(irq), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
